// File: rtl/mem_port_arbiter.sv
// Arbitrates the RV32I fetch and load/store requesters onto one single-ported memory.
// One access in flight at a time; every access is bounded by a watchdog and completes with a ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_STREAK     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ready,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ready,
    output logic                    err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitrates and launches the access
    // ACCESS | mem_req held; waits for mem_ack or watchdog expiry
    // RESP   | owner's ready pulses for one cycle (err set on timeout)

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   streak;
    logic [TW-1:0]   tmr;
    logic            owner_d;
    logic            any_req;
    logic            grant_d;
    logic            tmr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch is forced through once data has won MAX_STREAK times in a row over it.
    always_comb begin
        any_req   = if_req | d_req;
        grant_d   = d_req & ~(if_req & (streak == STREAK_MAX));
        tmr_done  = (tmr == '0);
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (mem_ack || tmr_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak    <= '0;
            tmr       <= '0;
            owner_d   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!if_req) begin
                        streak <= '0;
                    end else if (grant_d) begin
                        if (streak != STREAK_MAX) streak <= streak + SW'(1);
                    end else begin
                        streak <= '0;
                    end
                    if (any_req) begin
                        mem_req <= 1'b1;
                        owner_d <= grant_d;
                        tmr     <= TMR_LOAD;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_we ? d_be : '1;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        if (owner_d) begin
                            if (!mem_we) d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (tmr_done) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        if (owner_d) begin
                            d_rdata <= '0;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                RESP: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    err      <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic against a transaction-level model of the arbiter's
// grant policy, latency, watchdog and data return; includes async resets mid-access.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_STREAK(MAXS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int total = 0;
    int bad   = 0;

    // model of the outstanding transaction and arbiter history
    int          cyc;
    int          idle_edge;
    bit          inflight;
    bit          own_d;
    bit          own_we;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_be;
    int          n;
    int          plan;
    bit          ack_prev;
    logic [31:0] ack_data;
    int          streak;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    bit          exp_ifr;
    bit          exp_dr;
    bit          exp_err;
    bit          hog;
    bit          rst_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_port(input string tag);
        check({tag, "_req"},  mem_req,  1);
        check({tag, "_addr"}, mem_addr, g_addr);
        check({tag, "_we"},   mem_we,   own_we);
        check({tag, "_be"},   mem_be,   g_be);
        if (own_we) check({tag, "_wdata"}, mem_wdata, g_wdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   mem_req,   0);
        check({tag, "_mem_we"},    mem_we,    0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_be"},    mem_be,    0);
        check({tag, "_if_rdata"},  if_rdata,  0);
        check({tag, "_d_rdata"},   d_rdata,   0);
        check({tag, "_if_ready"},  if_ready,  0);
        check({tag, "_d_ready"},   d_ready,   0);
        check({tag, "_err"},       err,       0);
    endtask

    // Called at each falling edge: judge what the DUT did at the preceding rising edge,
    // then drive requesters and memory for the next one.
    task automatic step();
        bit data_wins;
        cyc++;
        exp_ifr = 0;
        exp_dr  = 0;
        exp_err = 0;
        if (inflight) begin
            if (ack_prev || n == TO) begin
                if (own_d) exp_dr = 1; else exp_ifr = 1;
                if (ack_prev) begin
                    if (!own_d) exp_if_rdata = ack_data;
                    else if (!own_we) exp_d_rdata = ack_data;
                end else begin
                    exp_err = 1;
                    if (own_d) exp_d_rdata = '0; else exp_if_rdata = '0;
                end
                inflight  = 0;
                idle_edge = cyc + 2;
                check("drop_req", mem_req, 0);
            end else begin
                n++;
                check_port("hold");
            end
        end else if (cyc >= idle_edge) begin
            if (!if_req) streak = 0;
            if (if_req || d_req) begin
                data_wins = d_req && !(if_req && streak == MAXS);
                if (data_wins) begin
                    if (if_req) streak++;
                    own_we  = d_we;
                    g_addr  = d_addr;
                    g_wdata = d_wdata;
                    g_be    = d_we ? d_be : 4'hF;
                end else begin
                    streak  = 0;
                    own_we  = 0;
                    g_addr  = if_addr;
                    g_wdata = '0;
                    g_be    = 4'hF;
                end
                own_d    = data_wins;
                inflight = 1;
                n        = 1;
                plan     = $urandom_range(0, 9);
                check_port("grant");
            end else begin
                check("idle_req", mem_req, 0);
            end
        end else begin
            check("resp_req", mem_req, 0);
        end
        check("if_ready",  if_ready, exp_ifr);
        check("d_ready",   d_ready,  exp_dr);
        check("err",       err,      exp_err);
        check("if_rdata",  if_rdata, exp_if_rdata);
        check("d_rdata",   d_rdata,  exp_d_rdata);
        check("one_ready", if_ready & d_ready, 0);

        if (exp_ifr) begin
            if_req = 0;
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (exp_dr) begin
            d_req = 0;
        end else if (!d_req && (hog || $urandom_range(0, 2) == 0)) begin
            d_req   = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(1, 15));
        end
        // the owner's payload may wander once granted; the memory port must not follow it
        if (inflight && $urandom_range(0, 3) == 0) begin
            if (own_d) begin
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end else begin
                if_addr = $urandom;
            end
        end
        mem_rdata = $urandom;
        if (inflight) mem_ack = (n == plan);
        else          mem_ack = ($urandom_range(0, 3) == 0);
        ack_prev = inflight && mem_ack;
        ack_data = mem_rdata;
    endtask

    task automatic mid_reset();
        #2 rst = 1;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_if_ready",  if_ready, 0);
        check("rst_d_ready",   d_ready, 0);
        @(negedge clk);
        cyc++;
        check_all_zero("rst_hold");
        inflight     = 0;
        streak       = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        ack_prev     = 0;
        if_req       = 0;
        d_req        = 0;
        mem_ack      = 1;
        @(negedge clk);
        cyc++;
        rst       = 0;
        idle_edge = cyc + 1;
        mem_ack   = 1;
        if_req    = 1;
        if_addr   = $urandom & 32'hFFFF_FFFC;
    endtask

    initial begin
        rst       = 1;
        if_req    = 0;
        if_addr   = '0;
        d_req     = 0;
        d_we      = 0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_rdata = '0;
        mem_ack   = 0;
        cyc          = 0;
        inflight     = 0;
        streak       = 0;
        ack_prev     = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        rst_pend     = 0;
        hog          = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst       = 0;
        idle_edge = cyc + 1;
        if_req    = 1;
        if_addr   = 32'h100;
        for (int i = 0; i < 6000; i++) begin
            hog = ((i / 400) % 2) == 1;
            @(negedge clk);
            step();
            if (i % 1000 == 900) rst_pend = 1;
            if (rst_pend && inflight) begin
                rst_pend = 0;
                mid_reset();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
